// File: rtl/tpu_isa_pkg.sv
// Shared ISA definitions for the instruction dispatcher.
// Contents: opcode constants, instruction field positions, execution-unit indices,
// error codes, the dispatcher state encoding, and an opcode-to-unit helper.
package tpu_isa_pkg;

  // Opcodes
  localparam logic [7:0] OpNop    = 8'h00;
  localparam logic [7:0] OpLoadW  = 8'h01;
  localparam logic [7:0] OpLoadIn = 8'h02;
  localparam logic [7:0] OpExec   = 8'h03;
  localparam logic [7:0] OpStore  = 8'h04;
  localparam logic [7:0] OpHalt   = 8'hFF;

  // Field positions; MSBs of len/src/dst depend on the width parameters
  localparam int unsigned OpcodeMsb = 127;
  localparam int unsigned OpcodeLsb = 120;
  localparam int unsigned LenLsb    = 64;
  localparam int unsigned SrcLsb    = 32;
  localparam int unsigned DstLsb    = 0;

  // Execution unit indices into unit_start / unit_done
  localparam int unsigned NumUnits   = 4;
  localparam int unsigned UnitLoadW  = 0;
  localparam int unsigned UnitLoadIn = 1;
  localparam int unsigned UnitExec   = 2;
  localparam int unsigned UnitStore  = 3;

  typedef enum logic [1:0] {
    ErrNone         = 2'd0,
    ErrIllegal      = 2'd1,
    ErrFetchTimeout = 2'd2,
    ErrExecTimeout  = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitInst,
    StIssue,
    StExec,
    StHalt,
    StError
  } state_e;

  // One-hot unit select for an opcode; zero for anything that is not a unit op
  function automatic logic [NumUnits-1:0] opcode_to_unit(input logic [7:0] op);
    logic [NumUnits-1:0] u;
    u = '0;
    unique case (op)
      OpLoadW:  u[UnitLoadW]  = 1'b1;
      OpLoadIn: u[UnitLoadIn] = 1'b1;
      OpExec:   u[UnitExec]   = 1'b1;
      OpStore:  u[UnitStore]  = 1'b1;
      default:  u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational instruction decoder.
// Ports:
//   instruction  in   raw instruction word
//   legal        out  opcode is one of NOP / unit op / HALT
//   is_nop       out  opcode is NOP
//   is_halt      out  opcode is HALT
//   unit         out  one-hot target unit (zero for NOP/HALT/illegal)
//   src, dst     out  address fields
//   len          out  length field
module inst_field_decode
  import tpu_isa_pkg::*;
#(
  parameter int unsigned INST_BITS = 128,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned LEN_BITS  = 16
) (
  input  logic [INST_BITS-1:0] instruction,
  output logic                 legal,
  output logic                 is_nop,
  output logic                 is_halt,
  output logic [NumUnits-1:0]  unit,
  output logic [ADDR_BITS-1:0] src,
  output logic [ADDR_BITS-1:0] dst,
  output logic [LEN_BITS-1:0]  len
);

  logic [7:0] opcode;

  // Bits outside the field map are deliberately ignored
  logic [INST_BITS-1:0] unused_inst;
  assign unused_inst = instruction;

  always_comb begin
    opcode  = instruction[OpcodeMsb:OpcodeLsb];
    len     = instruction[LenLsb+LEN_BITS-1:LenLsb];
    src     = instruction[SrcLsb+ADDR_BITS-1:SrcLsb];
    dst     = instruction[DstLsb+ADDR_BITS-1:DstLsb];
    unit    = opcode_to_unit(opcode);
    is_nop  = (opcode == OpNop);
    is_halt = (opcode == OpHalt);
    legal   = is_nop || is_halt || (|unit);
  end

endmodule

// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: fetches instructions from the PC / ISA memory, decodes them and
// hands each unit op to one of four execution units, waiting for its done before the next fetch.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               rising edge in IDLE begins the program
//   inst_valid          one-cycle pulse qualifying instruction
//   instruction         instruction word
//   fetch_flag          one-cycle fetch request to the PC
//   unit_start          one-hot start pulse {STORE, EXEC, LOAD_IN, LOAD_W}
//   unit_done           one-cycle done pulses from the units
//   op_src_addr/op_dst_addr/op_len  operand fields of the captured instruction
//   busy, halted, error, error_code status
//   retired_count       completed instructions (NOPs included), wrapping
module inst_dispatcher
  import tpu_isa_pkg::*;
#(
  parameter int unsigned INST_BITS     = 128,
  parameter int unsigned ADDR_BITS     = 32,
  parameter int unsigned LEN_BITS      = 16,
  parameter int unsigned FETCH_TIMEOUT = 64,
  parameter int unsigned EXEC_TIMEOUT  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 inst_valid,
  input  logic [INST_BITS-1:0] instruction,
  output logic                 fetch_flag,
  output logic [NumUnits-1:0]  unit_start,
  input  logic [NumUnits-1:0]  unit_done,
  output logic [ADDR_BITS-1:0] op_src_addr,
  output logic [ADDR_BITS-1:0] op_dst_addr,
  output logic [LEN_BITS-1:0]  op_len,
  output logic                 busy,
  output logic                 halted,
  output logic                 error,
  output logic [1:0]           error_code,
  output logic [15:0]          retired_count
);

  // The timer holds the number of completed cycles in the current state, so a state has
  // timed out once it is in its TIMEOUT-th cycle without the awaited event.
  localparam logic [31:0] FetchLimit = 32'(FETCH_TIMEOUT - 1);
  localparam logic [31:0] ExecLimit  = (EXEC_TIMEOUT == 0) ? 32'd0 : 32'(EXEC_TIMEOUT - 1);
  localparam bit          ExecToEn   = (EXEC_TIMEOUT != 0);

  state_e                state_q, state_d;
  logic                  start_ff;
  logic [31:0]           timer_q;
  logic [NumUnits-1:0]   unit_q;
  logic [ADDR_BITS-1:0]  src_q, dst_q;
  logic [LEN_BITS-1:0]   len_q;
  err_code_e             err_q, err_d;
  logic [15:0]           retired_q;

  logic                  capture, retire;
  logic                  dec_legal, dec_nop, dec_halt;
  logic [NumUnits-1:0]   dec_unit;
  logic [ADDR_BITS-1:0]  dec_src, dec_dst;
  logic [LEN_BITS-1:0]   dec_len;
  logic                  start_rise, fetch_expired, exec_expired;

  inst_field_decode #(
    .INST_BITS (INST_BITS),
    .ADDR_BITS (ADDR_BITS),
    .LEN_BITS  (LEN_BITS)
  ) u_decode (
    .instruction (instruction),
    .legal       (dec_legal),
    .is_nop      (dec_nop),
    .is_halt     (dec_halt),
    .unit        (dec_unit),
    .src         (dec_src),
    .dst         (dec_dst),
    .len         (dec_len)
  );

  always_comb begin
    start_rise    = start && !start_ff;
    fetch_expired = (timer_q >= FetchLimit);
    exec_expired  = ExecToEn && (timer_q >= ExecLimit);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    capture = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_rise) state_d = StFetch;
      end
      StFetch: begin
        state_d = StWaitInst;
      end
      StWaitInst: begin
        if (inst_valid) begin
          capture = 1'b1;
          if (!dec_legal) begin
            state_d = StError;
            err_d   = ErrIllegal;
          end else if (dec_nop) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else if (dec_halt) begin
            state_d = StHalt;
          end else begin
            state_d = StIssue;
          end
        end else if (fetch_expired) begin
          state_d = StError;
          err_d   = ErrFetchTimeout;
        end
      end
      StIssue: begin
        // Any done seen here is ignored: the unit has not been started yet
        state_d = StExec;
      end
      StExec: begin
        if (|(unit_done & unit_q)) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (exec_expired) begin
          state_d = StError;
          err_d   = ErrExecTimeout;
        end
      end
      StHalt, StError: begin
        state_d = state_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      start_ff  <= 1'b0;
      timer_q   <= '0;
      err_q     <= ErrNone;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      start_ff <= start;
      err_q    <= err_d;
      if (retire) retired_q <= retired_q + 16'd1;
      // Timer restarts on every state entry and saturates instead of wrapping
      if (state_d != state_q) begin
        timer_q <= '0;
      end else if (timer_q != 32'hFFFF_FFFF) begin
        timer_q <= timer_q + 32'd1;
      end
    end
  end

  // Captured instruction fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unit_q <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
    end else if (capture) begin
      unit_q <= dec_unit;
      src_q  <= dec_src;
      dst_q  <= dec_dst;
      len_q  <= dec_len;
    end
  end

  always_comb begin
    fetch_flag    = (state_q == StFetch);
    unit_start    = (state_q == StIssue) ? unit_q : '0;
    busy          = !((state_q == StIdle) || (state_q == StHalt) || (state_q == StError));
    halted        = (state_q == StHalt);
    error         = (state_q == StError);
    error_code    = err_q;
    op_src_addr   = src_q;
    op_dst_addr   = dst_q;
    op_len        = len_q;
    retired_count = retired_q;
  end

endmodule

// File: tb/tb_inst_dispatcher.sv
// Self-checking bench for inst_dispatcher: per-opcode vector table plus directed
// multi-cycle sequences (programs, timeouts, done filtering, async reset).
module tb_inst_dispatcher;
  import tpu_isa_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n, start, inst_valid;
  logic [127:0] instruction;
  logic [3:0]   unit_done;

  logic         fetch_flag, busy, halted, error;
  logic [3:0]   unit_start;
  logic [31:0]  op_src_addr, op_dst_addr;
  logic [15:0]  op_len, retired_count;
  logic [1:0]   error_code;

  // Second instance with an exec timeout enabled
  logic         t_fetch_flag, t_busy, t_halted, t_error;
  logic [3:0]   t_unit_start;
  logic [31:0]  t_src, t_dst;
  logic [15:0]  t_len, t_retired;
  logic [1:0]   t_error_code;

  always #5 clk = ~clk;

  inst_dispatcher #(.FETCH_TIMEOUT(64), .EXEC_TIMEOUT(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .inst_valid(inst_valid),
    .instruction(instruction), .fetch_flag(fetch_flag), .unit_start(unit_start),
    .unit_done(unit_done), .op_src_addr(op_src_addr), .op_dst_addr(op_dst_addr),
    .op_len(op_len), .busy(busy), .halted(halted), .error(error),
    .error_code(error_code), .retired_count(retired_count)
  );

  inst_dispatcher #(.FETCH_TIMEOUT(64), .EXEC_TIMEOUT(20)) dut_t (
    .clk(clk), .reset_n(reset_n), .start(start), .inst_valid(inst_valid),
    .instruction(instruction), .fetch_flag(t_fetch_flag), .unit_start(t_unit_start),
    .unit_done(unit_done), .op_src_addr(t_src), .op_dst_addr(t_dst),
    .op_len(t_len), .busy(t_busy), .halted(t_halted), .error(t_error),
    .error_code(t_error_code), .retired_count(t_retired)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts fetch pulses, back-to-back fetch cycles and unit starts
  int   fetch_cnt = 0, sep_viol = 0, start_cnt = 0;
  logic fetch_prev = 1'b0;
  always @(negedge clk) begin
    if (fetch_flag) begin
      fetch_cnt <= fetch_cnt + 1;
      if (fetch_prev) sep_viol <= sep_viol + 1;
    end
    fetch_prev <= fetch_flag;
    if (unit_start != 4'b0) start_cnt <= start_cnt + 1;
  end

  function automatic logic [127:0] mk_inst(input logic [7:0] op, input logic [31:0] src,
                                           input logic [31:0] dst, input logic [15:0] len);
    logic [127:0] w;
    w          = '0;
    w[127:120] = op;
    w[119:80]  = 40'hA55AC33C96;  // ignored bits carry noise
    w[79:64]   = len;
    w[63:32]   = src;
    w[31:0]    = dst;
    return w;
  endfunction

  task automatic do_reset();
    reset_n     = 1'b0;
    start       = 1'b0;
    inst_valid  = 1'b0;
    instruction = '0;
    unit_done   = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge of a FETCH cycle (checks the current cycle first)
  task automatic wait_fetch(input string name);
    int n = 0;
    while (!fetch_flag && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_fetch_seen"}, 64'(fetch_flag), 64'd1);
  endtask

  // Called at a FETCH negedge; presents the instruction in the first WAIT_INST cycle and
  // returns at the negedge of the cycle after capture
  task automatic give_inst(input logic [127:0] ins);
    @(negedge clk);
    inst_valid  = 1'b1;
    instruction = ins;
    @(negedge clk);
    inst_valid  = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [127:0] ins, input logic [3:0] exp_u,
                        input int dly);
    wait_fetch(name);
    give_inst(ins);
    check({name, "_unit_start"}, 64'(unit_start), 64'(exp_u));
    if (exp_u != 4'b0) begin
      check({name, "_src"}, 64'(op_src_addr), 64'(ins[63:32]));
      check({name, "_len"}, 64'(op_len), 64'(ins[79:64]));
      repeat (dly) @(negedge clk);
      check({name, "_fields_stable"}, {op_dst_addr, op_src_addr}, {ins[31:0], ins[63:32]});
      unit_done = exp_u;
      @(negedge clk);
      unit_done = 4'b0;
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [3:0]  unit;
    logic        err;
    logic [1:0]  code;
    logic        halt;
    logic [15:0] ret;
    logic        fetch;
  } vec_t;

  vec_t vecs[9];
  int   f0, s0, v0;

  initial begin
    vecs[0] = '{8'h00, 32'h11, 32'h22, 16'h33, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd1, 1'b1};
    vecs[1] = '{8'h01, 32'h100, 32'h0, 16'd16, 4'b0001, 1'b0, 2'd0, 1'b0, 16'd1, 1'b1};
    vecs[2] = '{8'h02, 32'hDEAD_BEEF, 32'h1234_5678, 16'hFFFF, 4'b0010, 1'b0, 2'd0, 1'b0,
                16'd1, 1'b1};
    vecs[3] = '{8'h03, 32'h0, 32'hFFFF_FFFF, 16'd8, 4'b0100, 1'b0, 2'd0, 1'b0, 16'd1, 1'b1};
    vecs[4] = '{8'h04, 32'h8000_0001, 32'h40, 16'h1, 4'b1000, 1'b0, 2'd0, 1'b0, 16'd1, 1'b1};
    vecs[5] = '{8'hFF, 32'h5, 32'h6, 16'h7, 4'b0000, 1'b0, 2'd0, 1'b1, 16'd0, 1'b0};
    vecs[6] = '{8'h7A, 32'h5, 32'h6, 16'h7, 4'b0000, 1'b1, 2'd1, 1'b0, 16'd0, 1'b0};
    vecs[7] = '{8'h05, 32'h5, 32'h6, 16'h7, 4'b0000, 1'b1, 2'd1, 1'b0, 16'd0, 1'b0};
    vecs[8] = '{8'hFE, 32'h5, 32'h6, 16'h7, 4'b0000, 1'b1, 2'd1, 1'b0, 16'd0, 1'b0};

    // Reset state
    do_reset();
    check("reset_outputs", {fetch_flag, unit_start, busy, halted, error, error_code},
          64'd0);
    check("reset_fields", {op_src_addr, op_dst_addr}, 64'd0);
    check("reset_len_retired", {op_len, retired_count}, 64'd0);
    repeat (3) @(negedge clk);
    check("idle_no_fetch", 64'(fetch_flag), 64'd0);

    // Single-instruction vectors
    for (int i = 0; i < 9; i++) begin
      logic [127:0] ins;
      ins = mk_inst(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].len);
      do_reset();
      pulse_start();
      wait_fetch("vec");
      give_inst(ins);
      check("vec_unit_start", 64'(unit_start), 64'(vecs[i].unit));
      check("vec_err", {error, error_code, halted}, {vecs[i].err, vecs[i].code, vecs[i].halt});
      if (vecs[i].unit != 4'b0) begin
        check("vec_fields", {op_src_addr, op_dst_addr}, {vecs[i].src, vecs[i].dst});
        check("vec_len", 64'(op_len), 64'(vecs[i].len));
        repeat (2) @(negedge clk);
        unit_done = vecs[i].unit;
        @(negedge clk);
        unit_done = 4'b0;
      end
      check("vec_retired", 64'(retired_count), 64'(vecs[i].ret));
      check("vec_fetch_after", 64'(fetch_flag), 64'(vecs[i].fetch));
    end

    // Program: LOAD_W, EXEC, HALT with done 5 cycles after start
    do_reset();
    #1;
    f0 = fetch_cnt; s0 = start_cnt;
    pulse_start();
    run_op("p1_loadw", mk_inst(8'h01, 32'h100, 32'h0, 16'd16), 4'b0001, 5);
    run_op("p1_exec", mk_inst(8'h03, 32'h0, 32'h0, 16'd8), 4'b0100, 5);
    wait_fetch("p1_halt");
    give_inst(mk_inst(8'hFF, 32'h0, 32'h0, 16'h0));
    pulse_start();  // ignored in HALT
    repeat (4) @(negedge clk);
    #1;
    check("p1_halted", {halted, busy, error}, 64'b100);
    check("p1_retired", 64'(retired_count), 64'd2);
    check("p1_fetches", 64'(fetch_cnt - f0), 64'd3);
    check("p1_starts", 64'(start_cnt - s0), 64'd2);

    // Program: NOP, NOP, STORE, HALT
    do_reset();
    #1;
    f0 = fetch_cnt; s0 = start_cnt; v0 = sep_viol;
    pulse_start();
    run_op("p2_nop0", mk_inst(8'h00, 32'h0, 32'h0, 16'h0), 4'b0000, 0);
    run_op("p2_nop1", mk_inst(8'h00, 32'h0, 32'h0, 16'h0), 4'b0000, 0);
    run_op("p2_store", mk_inst(8'h04, 32'hA0, 32'hB0, 16'd4), 4'b1000, 3);
    wait_fetch("p2_halt");
    give_inst(mk_inst(8'hFF, 32'h0, 32'h0, 16'h0));
    repeat (3) @(negedge clk);
    #1;
    check("p2_halted", 64'(halted), 64'd1);
    check("p2_retired", 64'(retired_count), 64'd3);
    check("p2_fetches", 64'(fetch_cnt - f0), 64'd4);
    check("p2_starts", 64'(start_cnt - s0), 64'd1);
    check("p2_fetch_gap", 64'(sep_viol - v0), 64'd0);

    // Illegal opcode: no further fetches, inst_valid ignored in ERROR
    do_reset();
    pulse_start();
    wait_fetch("ill");
    #1;
    f0 = fetch_cnt; s0 = start_cnt;
    give_inst(mk_inst(8'h7A, 32'h1, 32'h2, 16'h3));
    check("ill_err", {error, error_code}, 64'b101);
    give_inst(mk_inst(8'h00, 32'h1, 32'h2, 16'h3));
    repeat (5) @(negedge clk);
    #1;
    check("ill_no_fetch", 64'(fetch_cnt - f0), 64'd0);
    check("ill_no_start", 64'(start_cnt - s0), 64'd0);
    check("ill_sticky", {error, error_code, busy}, 64'b1010);

    // Fetch timeout: WAIT_INST lasts 64 cycles, ERROR follows
    do_reset();
    pulse_start();
    wait_fetch("fto");
    repeat (64) @(negedge clk);
    check("fto_last_wait", {error, busy}, 64'b01);
    @(negedge clk);
    check("fto_err", {error, error_code}, 64'b110);

    // Done filtering: only the issued unit's done retires the op
    do_reset();
    pulse_start();
    wait_fetch("filt");
    give_inst(mk_inst(8'h03, 32'h7, 32'h8, 16'h9));
    check("filt_issue", 64'(unit_start), 64'b0100);
    unit_done = 4'b0100;  // in ISSUE: ignored
    @(negedge clk);
    unit_done = 4'b0001;
    @(negedge clk);
    unit_done = 4'b1000;
    @(negedge clk);
    unit_done = 4'b0000;
    @(negedge clk);
    check("filt_wait", {busy, fetch_flag, unit_start, retired_count}, {1'b1, 1'b0, 4'b0, 16'd0});
    unit_done = 4'b0100;
    @(negedge clk);
    unit_done = 4'b0000;
    check("filt_fetch_next", {fetch_flag, retired_count}, {1'b1, 16'd1});
    check("filt_t_ok", {t_error, t_retired}, {1'b0, 16'd1});

    // Exec timeout on the EXEC_TIMEOUT=20 instance
    do_reset();
    pulse_start();
    wait_fetch("eto");
    give_inst(mk_inst(8'h03, 32'h7, 32'h8, 16'h9));
    repeat (20) @(negedge clk);
    check("eto_last_exec", {t_error, t_busy}, 64'b01);
    @(negedge clk);
    check("eto_err", {t_error, t_error_code}, 64'b111);
    check("eto_no_timeout_default", {error, busy}, 64'b01);

    // Async reset mid-EXEC
    do_reset();
    pulse_start();
    run_op("ar_nop", mk_inst(8'h00, 32'h0, 32'h0, 16'h0), 4'b0000, 0);
    wait_fetch("ar");
    give_inst(mk_inst(8'h02, 32'h55, 32'h66, 16'h77));
    @(negedge clk);
    check("ar_pre", {busy, retired_count}, {1'b1, 16'd1});
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_status", {fetch_flag, unit_start, busy, halted, error, error_code}, 64'd0);
    check("ar_fields", {op_src_addr, op_dst_addr}, 64'd0);
    check("ar_len_ret", {op_len, retired_count}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_fetch("ar_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
